trdb_packet_slicer: RTL and testbench
=====================================

# trdb_packet_slicer

Parametrised trace-packet egress buffer for the trace debugger. It accepts variable-length encoder packets of up to `PACKET_W` bits and queues up to `DEPTH` of them. It emits each queued packet as a sequence of `SLICE_W`-bit slices, LSB slice first, over a valid/ready stream. The trace source cannot stall, so packets arriving while the buffer is full are dropped and counted.

## Interface
- `PACKET_W`, 128: maximum packet width in bits.
- `SLICE_W`, 32: output slice width; must divide `PACKET_W`.
- `DEPTH`, 4: FIFO depth in packets; power of two, ≥ 2.
- `LEN_W`, $clog2(PACKET_W+1): derived, width of the length field.
- `CNT_W`, 16: width of the drop counter.
- `NSLICE`, PACKET_W/SLICE_W: derived.

Ports (name, direction, width, meaning):
- `clk_i` in 1: clock, all state on the rising edge.
- `rst_i` in 1: asynchronous active-high reset.
- `flush_i` in 1: synchronous clear of the FIFO and of any packet in progress.
- `packet_i` in `PACKET_W`: packet bits, LSB-aligned.
- `packet_len_i` in `LEN_W`: number of valid bits; 0 means `PACKET_W`; values > `PACKET_W` are clamped to `PACKET_W`.
- `packet_valid_i` in 1: push request; there is no ready.
- `slice_o` out `SLICE_W`: current slice.
- `slice_valid_o` out 1: slice available.
- `slice_ready_i` in 1: sink accepts the slice.
- `slice_last_o` out 1: current slice is the final slice of its packet.
- `fifo_full_o` out 1: FIFO holds `DEPTH` packets.
- `fifo_empty_o` out 1: FIFO holds 0 packets.
- `drop_o` out 1: one-cycle pulse when a packet is dropped.
- `drop_cnt_o` out `CNT_W`: saturating count of dropped packets.

## Operation
- **Write path**
  - On push, store `packet_i` and nslices = ceil(len/SLICE_W), range 1..`NSLICE`, computed at push time.
  - Write and read pointers are `$clog2(DEPTH)+1` bits wide; the extra MSB distinguishes full from empty, and both pointers wrap naturally.
- **Push acceptance**
  - Accepted if the FIFO is not full.
  - Also accepted when full if the head packet's last slice handshakes in the same cycle (simultaneous pop frees the slot).
  - Otherwise the packet is dropped: `drop_o`=1 and `drop_cnt_o` increments, saturating at 2^CNT_W−1.
- **Read FSM**
  - States are IDLE and SEND. A slice index `idx` counts 0..nslices−1.
  - IDLE → SEND when the FIFO is non-empty.
  - In SEND, `slice_o` = head[idx*SLICE_W +: SLICE_W] and `slice_last_o` = (idx == nslices−1).
  - On a handshake (`slice_valid_o` & `slice_ready_i`):
    - If not last: `idx`++.
    - If last: pop the head and set `idx`=0. Stay in SEND if another packet remains (back-to-back, no bubble); otherwise go to IDLE.
- **Flush**
  - Pointers are cleared, `idx`=0, FSM goes to IDLE.
  - A push in the same cycle as `flush_i` is discarded, not counted, and `drop_o` stays 0.
  - `drop_cnt_o` is preserved; only `rst_i` clears it.
- **Bit handling**
  - Bits above len within the final slice are passed through unmodified; no masking.

## Timing
- Reset values:
  - `slice_valid_o`=0, `slice_last_o`=0, `slice_o`=0.
  - `fifo_empty_o`=1, `fifo_full_o`=0.
  - `drop_o`=0, `drop_cnt_o`=0.
  - FSM in IDLE, pointers 0.
- Reset asserted mid-packet aborts the packet immediately (asynchronously), with no further slices.
- Latency: a push at edge N makes `slice_valid_o`=1 from N+1 when the FIFO was empty.
- Throughput: one slice per cycle while `slice_ready_i`=1.
- Valid/ready rules:
  - Once `slice_valid_o` is asserted, it and `slice_o`/`slice_last_o` hold stable until the handshake. The only exceptions are `flush_i` and `rst_i`.
  - `slice_valid_o` does not depend combinationally on `slice_ready_i`.
- Flags:
  - `fifo_full_o` and `fifo_empty_o` are registered-state-derived and reflect occupancy after the previous edge.
  - `drop_o` is registered: it is high in the cycle after the dropped push.
- After `flush_i` at edge N: `slice_valid_o`=0 from N+1.

## Test plan
- **Single push:** push len=128 (0x…DDDDCCCCBBBBAAAA), ready=1 → 4 slices 0xAAAA…, 0xBBBB…, 0xCCCC…, 0xDDDD… on consecutive cycles, `slice_last_o` only on the 4th, first slice 1 cycle after push.
- **Short and zero lengths:** push len=33 then len=0, ready=1 → 2 slices then 4 slices, back-to-back with no idle cycle between packets.
- **Overflow:** ready=0, push 6 packets of len=32 with DEPTH=4 → `fifo_full_o`=1 after 4th; pushes 5 and 6 dropped, `drop_o` pulses twice, `drop_cnt_o`=2; then ready=1 → exactly packets 1–4 emitted.
- **Full with simultaneous pop:** FIFO full, head on last slice, ready=1, push in same cycle → push accepted, `drop_cnt_o` unchanged, FIFO stays full.
- **Backpressure and flush:** random `slice_ready_i` → `slice_o` stable while stalled. `flush_i` mid-packet concurrent with a push → `slice_valid_o`=0 next cycle, `fifo_empty_o`=1, `drop_cnt_o` unchanged.
- **Saturation and reset:** with CNT_W=2, drop 5 packets → `drop_cnt_o`=3. Assert `rst_i` mid-packet → all outputs at reset values immediately.

Source files
------------

// File: rtl/trdb_packet_slicer_if.sv
// +-----------------------------------------------------------------------------+
// | trdb_packet_slicer_if: packet push / slice stream bundle for the slicer     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface trdb_packet_slicer_if #(
  parameter int PACKET_W = 128,
  parameter int SLICE_W  = 32,
  parameter int CNT_W    = 16,
  parameter int LEN_W    = $clog2(PACKET_W + 1)
);
  logic                flush_i;
  logic [PACKET_W-1:0] packet_i;
  logic [LEN_W-1:0]    packet_len_i;
  logic                packet_valid_i;
  logic [SLICE_W-1:0]  slice_o;
  logic                slice_valid_o;
  logic                slice_ready_i;
  logic                slice_last_o;
  logic                fifo_full_o;
  logic                fifo_empty_o;
  logic                drop_o;
  logic [CNT_W-1:0]    drop_cnt_o;

  modport slave (
    input  flush_i, packet_i, packet_len_i, packet_valid_i, slice_ready_i,
    output slice_o, slice_valid_o, slice_last_o, fifo_full_o, fifo_empty_o,
           drop_o, drop_cnt_o
  );

  modport master (
    output flush_i, packet_i, packet_len_i, packet_valid_i, slice_ready_i,
    input  slice_o, slice_valid_o, slice_last_o, fifo_full_o, fifo_empty_o,
           drop_o, drop_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/trdb_packet_slicer.sv
// +-----------------------------------------------------------------------------+
// | trdb_packet_slicer: trace-packet FIFO emitting packets as SLICE_W slices    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module trdb_packet_slicer #(
  parameter int PACKET_W = 128,
  parameter int SLICE_W  = 32,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16,
  parameter int LEN_W    = $clog2(PACKET_W + 1),
  parameter int NSLICE   = PACKET_W / SLICE_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  trdb_packet_slicer_if.slave  bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [LEN_W:0] C_PKT_LEN = (LEN_W + 1)'(PACKET_W);
  localparam logic [LEN_W:0] C_SLC_LEN = (LEN_W + 1)'(SLICE_W);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PACKET_W-1:0] mem_q [DEPTH];
  logic [PACKET_W-1:0] mem_d [DEPTH];
  logic [IDX_W-1:0]    last_idx_q [DEPTH];
  logic [IDX_W-1:0]    last_idx_d [DEPTH];
  logic                drop_q, drop_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

  logic [LEN_W:0]      len_eff;
  logic [IDX_W-1:0]    last_idx_in;
  logic [AW-1:0]       waddr, raddr;
  logic                empty, full, send, last, hs, pop, push, accept;

  // Each entry stores the index of its final slice, so ceil(len/SLICE_W) never has to be built.
  always_comb begin
    if (bus.packet_len_i == '0 || {1'b0, bus.packet_len_i} > C_PKT_LEN) begin
      len_eff = C_PKT_LEN;
    end else begin
      len_eff = {1'b0, bus.packet_len_i};
    end
    last_idx_in = IDX_W'((len_eff - (LEN_W + 1)'(1)) / C_SLC_LEN);
  end

  assign waddr  = wptr_q[AW-1:0];
  assign raddr  = rptr_q[AW-1:0];
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (waddr == raddr);
  assign send   = (state_q == SEND);
  assign last   = send && (idx_q == last_idx_q[raddr]);
  assign hs     = send && bus.slice_ready_i;
  assign pop    = hs && last;
  assign push   = bus.packet_valid_i && !bus.flush_i;
  assign accept = push && (!full || pop);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    idx_d      = idx_q;
    mem_d      = mem_q;
    last_idx_d = last_idx_q;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;
    if (bus.flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      idx_d  = '0;
    end else begin
      if (accept) begin
        mem_d[waddr]      = bus.packet_i;
        last_idx_d[waddr] = last_idx_in;
        wptr_d            = wptr_q + PTR_W'(1);
      end
      if (push && !accept) begin
        drop_d = 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
      end
      if (hs) begin
        if (last) begin
          idx_d  = '0;
          rptr_d = rptr_q + PTR_W'(1);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Decided on next-cycle occupancy so a push into an empty FIFO is visible one edge later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.flush_i && (wptr_d != rptr_d)) state_d = SEND;
      SEND:    if (bus.flush_i || (wptr_d == rptr_d)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      idx_q      <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]      <= '0;
        last_idx_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      idx_q      <= idx_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      mem_q      <= mem_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign bus.slice_o       = send ? mem_q[raddr][idx_q * SLICE_W +: SLICE_W] : '0;
  assign bus.slice_valid_o = send;
  assign bus.slice_last_o  = last;
  assign bus.fifo_full_o   = full;
  assign bus.fifo_empty_o  = empty;
  assign bus.drop_o        = drop_q;
  assign bus.drop_cnt_o    = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_trdb_packet_slicer.sv
// +-----------------------------------------------------------------------------+
// | tb_trdb_packet_slicer: directed vector bench for trdb_packet_slicer         |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_trdb_packet_slicer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trdb_packet_slicer_if #(.PACKET_W(128), .SLICE_W(32), .CNT_W(16)) bus ();
  trdb_packet_slicer_if #(.PACKET_W(128), .SLICE_W(32), .CNT_W(2))  bus2 ();

  trdb_packet_slicer #(.PACKET_W(128), .SLICE_W(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  trdb_packet_slicer #(.PACKET_W(128), .SLICE_W(32), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .bus(bus2)
  );

  typedef struct {
    logic [127:0] pkt;
    logic [7:0]   len;
    int           nsl;
  } vec_t;

  vec_t vecs [8];
  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] P_ABCD = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] P_1234 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] P_MIX  = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] pkt, input logic [7:0] len);
    bus.packet_i       = pkt;
    bus.packet_len_i   = len;
    bus.packet_valid_i = 1'b1;
  endtask

  initial begin
    logic [127:0] p;
    int exp_i;
    bit hs;

    bus.flush_i = 0; bus.packet_i = '0; bus.packet_len_i = '0;
    bus.packet_valid_i = 0; bus.slice_ready_i = 0;
    bus2.flush_i = 0; bus2.packet_i = '0; bus2.packet_len_i = '0;
    bus2.packet_valid_i = 0; bus2.slice_ready_i = 0;

    vecs[0] = '{P_ABCD, 8'd128, 4};
    vecs[1] = '{P_ABCD, 8'd33,  2};
    vecs[2] = '{P_MIX,  8'd0,   4};
    vecs[3] = '{P_1234, 8'd1,   1};
    vecs[4] = '{P_1234, 8'd32,  1};
    vecs[5] = '{P_MIX,  8'd64,  2};
    vecs[6] = '{P_MIX,  8'd65,  3};
    vecs[7] = '{P_1234, 8'd200, 4};

    tick; tick;
    chk("rst valid", bus.slice_valid_o, 0);
    chk("rst last",  bus.slice_last_o, 0);
    chk("rst slice", bus.slice_o, 0);
    chk("rst empty", bus.fifo_empty_o, 1);
    chk("rst full",  bus.fifo_full_o, 0);
    chk("rst drop",  bus.drop_o, 0);
    chk("rst cnt",   bus.drop_cnt_o, 0);
    rst = 0;
    tick;

    // Table: one packet at a time, sink always ready
    for (int v = 0; v < 8; v++) begin
      bus.slice_ready_i = 1;
      push(vecs[v].pkt, vecs[v].len);
      tick;
      bus.packet_valid_i = 0;
      for (int s = 0; s < vecs[v].nsl; s++) begin
        p = vecs[v].pkt;
        chk($sformatf("v%0d s%0d valid", v, s), bus.slice_valid_o, 1);
        chk($sformatf("v%0d s%0d slice", v, s), bus.slice_o, p[s*32 +: 32]);
        chk($sformatf("v%0d s%0d last", v, s), bus.slice_last_o, (s == vecs[v].nsl - 1));
        tick;
      end
      chk($sformatf("v%0d idle valid", v), bus.slice_valid_o, 0);
      chk($sformatf("v%0d idle empty", v), bus.fifo_empty_o, 1);
    end

    // Back-to-back len=33 then len=0, no bubble
    push(P_ABCD, 8'd33);
    tick;
    push(P_MIX, 8'd0);
    chk("b2b a0", bus.slice_o, P_ABCD[31:0]);
    chk("b2b a0 last", bus.slice_last_o, 0);
    tick;
    bus.packet_valid_i = 0;
    chk("b2b a1", bus.slice_o, P_ABCD[63:32]);
    chk("b2b a1 last", bus.slice_last_o, 1);
    tick;
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("b2b b%0d valid", s), bus.slice_valid_o, 1);
      chk($sformatf("b2b b%0d", s), bus.slice_o, P_MIX[s*32 +: 32]);
      chk($sformatf("b2b b%0d last", s), bus.slice_last_o, (s == 3));
      tick;
    end
    chk("b2b end valid", bus.slice_valid_o, 0);

    // Overflow with the sink stalled
    bus.slice_ready_i = 0;
    for (int i = 0; i < 6; i++) begin
      push({96'h0, 32'hC0DE0000 + 32'(i)}, 8'd32);
      tick;
      if (i == 2) chk("ovf not full", bus.fifo_full_o, 0);
      if (i == 3) chk("ovf full", bus.fifo_full_o, 1);
      if (i >= 4) chk($sformatf("ovf drop %0d", i), bus.drop_o, 1);
      if (i < 4)  chk($sformatf("ovf nodrop %0d", i), bus.drop_o, 0);
    end
    bus.packet_valid_i = 0;
    tick;
    chk("ovf drop clr", bus.drop_o, 0);
    chk("ovf cnt", bus.drop_cnt_o, 2);
    bus.slice_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf out%0d valid", i), bus.slice_valid_o, 1);
      chk($sformatf("ovf out%0d", i), bus.slice_o, 32'hC0DE0000 + 32'(i));
      chk($sformatf("ovf out%0d last", i), bus.slice_last_o, 1);
      tick;
    end
    chk("ovf drained", bus.slice_valid_o, 0);

    // Full, head on its last slice, push with simultaneous pop
    bus.slice_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      push({96'h0, 32'hBEEF0000 + 32'(i)}, 8'd32);
      tick;
    end
    chk("sim full before", bus.fifo_full_o, 1);
    bus.slice_ready_i = 1;
    push({96'h0, 32'hBEEF0004}, 8'd32);
    tick;
    bus.packet_valid_i = 0;
    chk("sim full after", bus.fifo_full_o, 1);
    chk("sim drop", bus.drop_o, 0);
    chk("sim cnt", bus.drop_cnt_o, 2);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("sim out%0d", i), bus.slice_o, 32'hBEEF0000 + 32'(i));
      tick;
    end
    chk("sim empty", bus.fifo_empty_o, 1);

    // Random backpressure: slice must hold until accepted
    bus.slice_ready_i = 0;
    push(P_MIX, 8'd0);
    tick;
    bus.packet_valid_i = 0;
    exp_i = 0;
    for (int c = 0; c < 60 && exp_i < 4; c++) begin
      chk($sformatf("bp c%0d valid", c), bus.slice_valid_o, 1);
      chk($sformatf("bp c%0d slice", c), bus.slice_o, P_MIX[exp_i*32 +: 32]);
      bus.slice_ready_i = 1'($urandom_range(0, 1));
      hs = bus.slice_ready_i;
      tick;
      if (hs) exp_i++;
    end
    chk("bp completed", exp_i, 4);
    bus.slice_ready_i = 1;
    tick;
    chk("bp idle", bus.slice_valid_o, 0);

    // Flush mid-packet with a concurrent push
    push(P_ABCD, 8'd0);
    tick;
    bus.packet_valid_i = 0;
    tick;
    chk("fl mid slice", bus.slice_o, P_ABCD[63:32]);
    bus.flush_i = 1;
    push(P_1234, 8'd0);
    tick;
    bus.flush_i = 0;
    bus.packet_valid_i = 0;
    chk("fl valid", bus.slice_valid_o, 0);
    chk("fl empty", bus.fifo_empty_o, 1);
    chk("fl drop", bus.drop_o, 0);
    chk("fl cnt", bus.drop_cnt_o, 2);
    tick;
    chk("fl push discarded", bus.slice_valid_o, 0);

    // Saturating 2-bit drop counter
    bus2.slice_ready_i = 0;
    for (int i = 0; i < 9; i++) begin
      bus2.packet_i = {96'h0, 32'(i)};
      bus2.packet_len_i = 8'd32;
      bus2.packet_valid_i = 1;
      tick;
      if (i == 6) chk("sat cnt3", bus2.drop_cnt_o, 3);
    end
    bus2.packet_valid_i = 0;
    tick;
    chk("sat cnt final", bus2.drop_cnt_o, 3);

    // Asynchronous reset mid-packet
    bus.slice_ready_i = 1;
    push(P_ABCD, 8'd0);
    tick;
    bus.packet_valid_i = 0;
    chk("ar pre valid", bus.slice_valid_o, 1);
    #1 rst = 1;
    #1;
    chk("ar valid", bus.slice_valid_o, 0);
    chk("ar last",  bus.slice_last_o, 0);
    chk("ar slice", bus.slice_o, 0);
    chk("ar empty", bus.fifo_empty_o, 1);
    chk("ar full",  bus.fifo_full_o, 0);
    chk("ar drop",  bus.drop_o, 0);
    chk("ar cnt",   bus.drop_cnt_o, 0);
    chk("ar sat cnt", bus2.drop_cnt_o, 0);
    tick;
    rst = 0;
    tick;
    chk("ar post valid", bus.slice_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
